s2mm_burst_framer: RTL and testbench

//  Upstream feeder of the BRAM/DataMover S2MM path: takes a free-running 32-bit sample stream, cuts it into

---
 rtl/s2mm_burst_framer.sv | 156 +++++++++++++++
 tb/tb_s2mm_burst_framer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_burst_framer.sv
// Cuts a free-running 32-bit sample stream into fixed bursts for the DataMover S2MM path.
// Optional status watchdog is enabled by defining S2MM_STS_TIMEOUT_EN.
module s2mm_burst_framer #(
    parameter int unsigned BURST_WORDS = 128,
    parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
    parameter logic [31:0] RING_BYTES  = 32'h0000_8000,
    parameter int unsigned STS_TIMEOUT = 1024
) (
    input  logic        clk_in1,
    input  logic        aresetn,
    input  logic        enable,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [71:0] m_axis_s2mm_cmd_tdata,
    output logic        m_axis_s2mm_cmd_tvalid,
    input  logic        m_axis_s2mm_cmd_tready,
    output logic [31:0] m_axis_s2mm_tdata,
    output logic [3:0]  m_axis_s2mm_tkeep,
    output logic        m_axis_s2mm_tlast,
    output logic        m_axis_s2mm_tvalid,
    input  logic        m_axis_s2mm_tready,
    input  logic [7:0]  s_axis_s2mm_sts_tdata,
    input  logic        s_axis_s2mm_sts_tvalid,
    output logic        s_axis_s2mm_sts_tready,
    output logic [31:0] burst_count,
    output logic        err_flag,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StCmd, StData, StSts} state_e;

    localparam logic [31:0] BurstBytes = 32'(4 * BURST_WORDS);
    localparam logic [22:0] Btt        = 23'(4 * BURST_WORDS);
    localparam logic [20:0] LastBeat   = 21'(BURST_WORDS - 1);
    localparam logic [31:0] RingEnd    = BASE_ADDR + RING_BYTES;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [3:0]  tag_q;
    logic [20:0] beat_q;
    logic [71:0] cmd_tdata_q;
    logic        cmd_tvalid_q;
    logic        sts_tready_q;
    logic [31:0] burst_count_q;
    logic        err_flag_q;

    logic        in_data;
    logic        data_hs;
    logic        sts_hs;
    logic        sts_ok;
    logic        sts_timeout;
    logic        sts_done;
    logic [31:0] addr_inc;
    logic [31:0] addr_next;

    // Data phase is a pure pass-through so the framer adds no bubbles to the stream.
    assign in_data   = (state_q == StData);
    assign data_hs   = in_data & s_axis_tvalid & m_axis_s2mm_tready;

    assign s_axis_tready          = in_data & m_axis_s2mm_tready;
    assign m_axis_s2mm_tvalid     = in_data & s_axis_tvalid;
    assign m_axis_s2mm_tdata      = in_data ? s_axis_tdata : 32'h0;
    assign m_axis_s2mm_tkeep      = 4'hF;
    assign m_axis_s2mm_tlast      = in_data & (beat_q == LastBeat);
    assign m_axis_s2mm_cmd_tdata  = cmd_tdata_q;
    assign m_axis_s2mm_cmd_tvalid = cmd_tvalid_q;
    assign s_axis_s2mm_sts_tready = sts_tready_q;
    assign burst_count            = burst_count_q;
    assign err_flag               = err_flag_q;
    assign busy                   = (state_q != StIdle);

    // A good status has OKAY alone among the four flag bits and echoes the issued tag.
    assign sts_hs    = sts_tready_q & s_axis_s2mm_sts_tvalid;
    assign sts_ok    = (s_axis_s2mm_sts_tdata[7:4] == 4'b1000) &&
                       (s_axis_s2mm_sts_tdata[3:0] == tag_q);
    assign addr_inc  = addr_q + BurstBytes;
    assign addr_next = (addr_inc == RingEnd) ? BASE_ADDR : addr_inc;

`ifdef S2MM_STS_TIMEOUT_EN
    logic [31:0] sts_cnt_q;

    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) begin
            sts_cnt_q <= 32'h0;
        end else if (state_q != StSts) begin
            sts_cnt_q <= 32'h0;
        end else begin
            sts_cnt_q <= sts_cnt_q + 32'd1;
        end
    end

    assign sts_timeout = (state_q == StSts) && !s_axis_s2mm_sts_tvalid &&
                         (sts_cnt_q == STS_TIMEOUT - 1);
`else
    assign sts_timeout = 1'b0;
`endif

    assign sts_done = sts_hs | sts_timeout;

    always_ff @(posedge clk_in1 or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            addr_q        <= BASE_ADDR;
            tag_q         <= 4'h0;
            beat_q        <= 21'h0;
            cmd_tdata_q   <= 72'h0;
            cmd_tvalid_q  <= 1'b0;
            sts_tready_q  <= 1'b0;
            burst_count_q <= 32'h0;
            err_flag_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable && s_axis_tvalid) begin
                        cmd_tdata_q  <= {4'h0, tag_q, addr_q, 1'b0, 1'b1, 6'h00, 1'b1, Btt};
                        cmd_tvalid_q <= 1'b1;
                        state_q      <= StCmd;
                    end
                end
                StCmd: begin
                    if (m_axis_s2mm_cmd_tready) begin
                        cmd_tvalid_q <= 1'b0;
                        beat_q       <= 21'h0;
                        state_q      <= StData;
                    end
                end
                StData: begin
                    if (data_hs) begin
                        beat_q <= beat_q + 21'd1;
                        if (beat_q == LastBeat) begin
                            sts_tready_q <= 1'b1;
                            state_q      <= StSts;
                        end
                    end
                end
                StSts: begin
                    if (sts_done) begin
                        sts_tready_q <= 1'b0;
                        if (sts_hs && sts_ok) begin
                            burst_count_q <= burst_count_q + 32'd1;
                        end else begin
                            err_flag_q <= 1'b1;
                        end
                        // Bad or missing status still retires the slot so the ring keeps moving.
                        tag_q   <= tag_q + 4'd1;
                        addr_q  <= addr_next;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_s2mm_burst_framer.sv
// Directed bench for s2mm_burst_framer: scoreboard on the data path, reference model for commands.
// Also exercises the status watchdog when built with S2MM_STS_TIMEOUT_EN.
module tb_s2mm_burst_framer;

    localparam int unsigned BurstWords = 128;
    localparam logic [31:0] BaseAddr   = 32'hC000_0000;
    localparam int unsigned StsTimeout = 1024;

    logic        clk_in1 = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [71:0] m_axis_s2mm_cmd_tdata;
    logic        m_axis_s2mm_cmd_tvalid;
    logic        m_axis_s2mm_cmd_tready;
    logic [31:0] m_axis_s2mm_tdata;
    logic [3:0]  m_axis_s2mm_tkeep;
    logic        m_axis_s2mm_tlast;
    logic        m_axis_s2mm_tvalid;
    logic        m_axis_s2mm_tready;
    logic [7:0]  s_axis_s2mm_sts_tdata;
    logic        s_axis_s2mm_sts_tvalid;
    logic        s_axis_s2mm_sts_tready;
    logic [31:0] burst_count;
    logic        err_flag;
    logic        busy;

    s2mm_burst_framer #(
        .BURST_WORDS (BurstWords),
        .BASE_ADDR   (BaseAddr),
        .RING_BYTES  (32'h0000_8000),
        .STS_TIMEOUT (StsTimeout)
    ) dut (
        .clk_in1                (clk_in1),
        .aresetn                (aresetn),
        .enable                 (enable),
        .s_axis_tdata           (s_axis_tdata),
        .s_axis_tvalid          (s_axis_tvalid),
        .s_axis_tready          (s_axis_tready),
        .m_axis_s2mm_cmd_tdata  (m_axis_s2mm_cmd_tdata),
        .m_axis_s2mm_cmd_tvalid (m_axis_s2mm_cmd_tvalid),
        .m_axis_s2mm_cmd_tready (m_axis_s2mm_cmd_tready),
        .m_axis_s2mm_tdata      (m_axis_s2mm_tdata),
        .m_axis_s2mm_tkeep      (m_axis_s2mm_tkeep),
        .m_axis_s2mm_tlast      (m_axis_s2mm_tlast),
        .m_axis_s2mm_tvalid     (m_axis_s2mm_tvalid),
        .m_axis_s2mm_tready     (m_axis_s2mm_tready),
        .s_axis_s2mm_sts_tdata  (s_axis_s2mm_sts_tdata),
        .s_axis_s2mm_sts_tvalid (s_axis_s2mm_sts_tvalid),
        .s_axis_s2mm_sts_tready (s_axis_s2mm_sts_tready),
        .burst_count            (burst_count),
        .err_flag               (err_flag),
        .busy                   (busy)
    );

    always #5 clk_in1 = ~clk_in1;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sample_next;
    logic [31:0] exp_q[$];
    int          beat_cnt;
    int          beats_at_last;
    bit          last_seen;
    bit          bp;
    bit          sts_want;
    logic [7:0]  sts_word;
    logic [71:0] last_cmd;
    int          m_idx;
    int          m_count;
    bit          m_err;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk_cmd(input int idx);
        logic [31:0] a;
        logic [3:0]  t;
        a = BaseAddr + 32'((idx * 512) % 32768);
        t = 4'(idx % 16);
        return {4'h0, t, a, 1'b0, 1'b1, 6'h00, 1'b1, 23'd512};
    endfunction

    // One clock: drive at the falling edge, observe 1ns later, account handshakes.
    task automatic tick();
        @(negedge clk_in1);
        if (bp) begin
            s_axis_tvalid          = ($urandom_range(0, 3) != 0);
            m_axis_s2mm_tready     = ($urandom_range(0, 2) != 0);
            m_axis_s2mm_cmd_tready = ($urandom_range(0, 1) != 0);
        end else begin
            s_axis_tvalid          = 1'b1;
            m_axis_s2mm_tready     = 1'b1;
            m_axis_s2mm_cmd_tready = 1'b1;
        end
        s_axis_tdata           = sample_next;
        s_axis_s2mm_sts_tvalid = sts_want;
        s_axis_s2mm_sts_tdata  = sts_word;
        #1;
        if (s_axis_tvalid && s_axis_tready) begin
            exp_q.push_back(sample_next);
            sample_next++;
        end
        if (m_axis_s2mm_tvalid && m_axis_s2mm_tready) begin
            if (exp_q.size() == 0) chk("data_underflow", 72'd1, 72'd0);
            else chk("data", 72'(m_axis_s2mm_tdata), 72'(exp_q.pop_front()));
            chk("tlast", 72'(m_axis_s2mm_tlast), 72'(beat_cnt == BurstWords - 1));
            beat_cnt++;
            if (m_axis_s2mm_tlast) begin
                last_seen     = 1'b1;
                beats_at_last = beat_cnt;
                beat_cnt      = 0;
            end
        end
    endtask

    task automatic check_reset_values(input string phase);
        chk({phase, "_busy"}, 72'(busy), 72'd0);
        chk({phase, "_cmd_tvalid"}, 72'(m_axis_s2mm_cmd_tvalid), 72'd0);
        chk({phase, "_cmd_tdata"}, m_axis_s2mm_cmd_tdata, 72'd0);
        chk({phase, "_m_tvalid"}, 72'(m_axis_s2mm_tvalid), 72'd0);
        chk({phase, "_m_tlast"}, 72'(m_axis_s2mm_tlast), 72'd0);
        chk({phase, "_s_tready"}, 72'(s_axis_tready), 72'd0);
        chk({phase, "_sts_tready"}, 72'(s_axis_s2mm_sts_tready), 72'd0);
        chk({phase, "_burst_count"}, 72'(burst_count), 72'd0);
        chk({phase, "_err_flag"}, 72'(err_flag), 72'd0);
    endtask

    task automatic run_burst(input int drop_at, input int reset_at, input bit custom,
                             input logic [7:0] sts_custom, input bit withhold);
        logic [71:0] exp_cmd;
        logic [71:0] held;
        logic [7:0]  sts;
        bit          seen;
        bit          stable;
        bit          hs;
        bit          done;
        bit          pass;
        int          n;
        exp_cmd = mk_cmd(m_idx);
        held    = 72'h0;
        seen    = 1'b0;
        stable  = 1'b1;
        hs      = 1'b0;
        n       = 0;
        while (!hs && n < 400) begin
            tick();
            if (m_axis_s2mm_cmd_tvalid) begin
                if (seen && m_axis_s2mm_cmd_tdata !== held) stable = 1'b0;
                held = m_axis_s2mm_cmd_tdata;
                seen = 1'b1;
                hs   = m_axis_s2mm_cmd_tready;
            end
            n++;
        end
        chk("cmd_handshake", 72'(hs), 72'd1);
        chk("cmd_stable", 72'(stable), 72'd1);
        chk("cmd_tdata", held, exp_cmd);
        last_cmd = held;

        last_seen = 1'b0;
        n = 0;
        while (!last_seen && n < 3000) begin
            if (drop_at >= 0 && beat_cnt == drop_at) enable = 1'b0;
            if (reset_at >= 0 && beat_cnt == reset_at) begin
                @(negedge clk_in1);
                aresetn = 1'b0;
                #1;
                check_reset_values("midreset");
                exp_q.delete();
                beat_cnt = 0;
                m_idx    = 0;
                m_count  = 0;
                m_err    = 1'b0;
                return;
            end
            tick();
            n++;
        end
        chk("burst_done", 72'(last_seen), 72'd1);
        chk("beats_per_burst", 72'(beats_at_last), 72'(BurstWords));
        chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);

        sts = custom ? sts_custom : {4'h8, m_idx[3:0]};
        if (withhold) begin
            sts_want = 1'b0;
            done     = 1'b0;
            n        = 0;
            while (!done && n < StsTimeout + 50) begin
                tick();
                done = !busy;
                n++;
            end
            chk("timeout_idle", 72'(done), 72'd1);
            chk("timeout_err", 72'(err_flag), 72'd1);
            m_err = 1'b1;
            m_idx++;
        end else begin
            sts_want = 1'b1;
            sts_word = sts;
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 100) begin
                tick();
                if (n == 0) chk("no_beat_in_sts", 72'(s_axis_tready), 72'd0);
                hs = s_axis_s2mm_sts_tready && s_axis_s2mm_sts_tvalid;
                n++;
            end
            sts_want = 1'b0;
            chk("sts_handshake", 72'(hs), 72'd1);
            pass = (sts[7:4] == 4'h8) && (sts[3:0] == m_idx[3:0]);
            if (pass) m_count++;
            else m_err = 1'b1;
            m_idx++;
            tick();
            chk("idle_gap", 72'(busy), 72'd0);
        end
        chk("burst_count", 72'(burst_count), 72'(m_count));
        chk("err_flag", 72'(err_flag), 72'(m_err));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn                = 1'b0;
        enable                 = 1'b0;
        s_axis_tdata           = 32'h0;
        s_axis_tvalid          = 1'b0;
        m_axis_s2mm_cmd_tready = 1'b0;
        m_axis_s2mm_tready     = 1'b0;
        s_axis_s2mm_sts_tdata  = 8'h0;
        s_axis_s2mm_sts_tvalid = 1'b0;
        bp          = 1'b0;
        sts_want    = 1'b0;
        sts_word    = 8'h0;
        sample_next = 32'h0;
        beat_cnt    = 0;
        m_idx       = 0;
        m_count     = 0;
        m_err       = 1'b0;
        last_cmd    = 72'h0;

        repeat (3) @(negedge clk_in1);
        #1;
        check_reset_values("reset");
        chk("reset_tkeep", 72'(m_axis_s2mm_tkeep), 72'hF);
        aresetn = 1'b1;

        // First burst: fixed command word, 128 beats of 0..127, OKAY status.
        enable = 1'b1;
        run_burst(-1, -1, 1'b0, 8'h00, 1'b0);
        chk("t1_cmd_word", last_cmd, 72'h00_C0000000_40800200);
        chk("t1_count", 72'(burst_count), 72'd1);

        // Fill the ring: burst 65 wraps back to the base address with tag 0.
        for (int i = 1; i <= 64; i++) begin
            run_burst(-1, -1, 1'b0, 8'h00, 1'b0);
            if (i == 1) chk("t1_second_cmd", last_cmd, 72'h01_C0000200_40800200);
            if (i == 64) chk("t2_wrap_cmd", last_cmd, 72'h00_C0000000_40800200);
        end
        chk("t2_count", 72'(burst_count), 72'd65);

        // SLVERR on the tag-1 burst.
        run_burst(-1, -1, 1'b1, 8'hC1, 1'b0);
        chk("t3_err", 72'(err_flag), 72'd1);
        chk("t3_count_held", 72'(burst_count), 72'd65);

        // Random backpressure on data and command channels.
        bp = 1'b1;
        run_burst(-1, -1, 1'b0, 8'h00, 1'b0);
        chk("t3_next_tag", 72'(last_cmd[67:64]), 72'h2);
        run_burst(-1, -1, 1'b0, 8'h00, 1'b0);
        run_burst(-1, -1, 1'b0, 8'h00, 1'b0);
        bp = 1'b0;

        // Enable dropped mid-burst: burst completes, no new command follows.
        run_burst(50, -1, 1'b0, 8'h00, 1'b0);
        repeat (5) tick();
        chk("t5_busy", 72'(busy), 72'd0);
        chk("t5_no_cmd", 72'(m_axis_s2mm_cmd_tvalid), 72'd0);
        chk("t5_no_ready", 72'(s_axis_tready), 72'd0);
        enable = 1'b1;

        // Reset at beat 10, then the ring restarts from the base address.
        run_burst(-1, 10, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk_in1);
        aresetn = 1'b1;
        run_burst(-1, -1, 1'b0, 8'h00, 1'b0);
        chk("t6_restart_cmd", last_cmd, 72'h00_C0000000_40800200);
        chk("t6_count", 72'(burst_count), 72'd1);

`ifdef S2MM_STS_TIMEOUT_EN
        run_burst(-1, -1, 1'b0, 8'h00, 1'b1);
        chk("t6_timeout_count", 72'(burst_count), 72'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
